// File: rtl/mem_bus_pkg.sv
// Shared definitions for the line-transfer bus: command encodings, the
// master's state set, and helpers that derive widths from the bus geometry.
// The memory model uses the same encodings.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        C2_NOP      = 2'd0,
        C2_RESPONSE = 2'd1,
        C2_READ     = 2'd2,
        C2_WRITE    = 2'd3
    } cmd_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CMD  = 3'd1,
        WAIT = 3'd2,
        XFER = 3'd3,
        DONE = 3'd4
    } state_e;

    localparam int DEF_MEM_ADDR_SIZE     = 19;
    localparam int DEF_CACHE_OFFSET_SIZE = 4;
    localparam int DEF_BUS_SIZE          = 16;
    localparam int DEF_CACHE_LINE_SIZE   = 16;
    localparam int DEF_TIMEOUT           = 1023;

    // Number of bus beats that make up one cache line.
    function automatic int calc_beats(input int line_bytes, input int bus_bits);
        return (line_bytes * 8) / bus_bits;
    endfunction

    // Counter width able to index n items; never narrower than one bit.
    function automatic int calc_idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Counter width able to hold the value n itself.
    function automatic int calc_cnt_width(input int n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

endpackage

// File: rtl/mem_bus_master.sv
// Cache-line bus master: accepts one line read or write request at a time,
// issues it on the shared command bus, then moves the line beat by beat,
// one beat per RESPONSE cycle from memory, beat 0 first.
//
// state | meaning
// IDLE  | ready for a line request
// CMD   | drive READ/WRITE on command for exactly one cycle
// WAIT  | waiting for the first RESPONSE
// XFER  | moving the remaining beats
// DONE  | one-cycle resp_valid, then back to IDLE
module mem_bus_master
    import mem_bus_pkg::*;
#(
    parameter int MEM_ADDR_SIZE     = 19,
    parameter int CACHE_OFFSET_SIZE = 4,
    parameter int BUS_SIZE          = 16,
    parameter int CACHE_LINE_SIZE   = 16,
    parameter int TIMEOUT           = 1023
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       req_valid,
    output logic                                       req_ready,
    input  logic                                       req_write,
    input  logic [MEM_ADDR_SIZE-CACHE_OFFSET_SIZE-1:0] req_addr,
    input  logic [CACHE_LINE_SIZE*8-1:0]               req_wdata,
    output logic                                       resp_valid,
    output logic [CACHE_LINE_SIZE*8-1:0]               resp_rdata,
    output logic                                       resp_err,
    output logic [MEM_ADDR_SIZE-CACHE_OFFSET_SIZE-1:0] address,
    inout  wire  [BUS_SIZE-1:0]                        data,
    inout  wire  [1:0]                                 command
);

    localparam int LA      = MEM_ADDR_SIZE - CACHE_OFFSET_SIZE;
    localparam int LINE_W  = CACHE_LINE_SIZE * 8;
    localparam int BEATS   = calc_beats(CACHE_LINE_SIZE, BUS_SIZE);
    localparam int BEAT_W  = calc_idx_width(BEATS);
    localparam int STALL_W = calc_cnt_width(TIMEOUT);

    localparam logic [BEAT_W-1:0]  LAST_BEAT  = BEAT_W'(BEATS - 1);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT - 1);

    state_e               state_q, state_d;
    logic [LA-1:0]        addr_q;
    logic                 write_q;
    logic [LINE_W-1:0]    wdata_q;
    logic [LINE_W-1:0]    rbuf_q, rbuf_d;
    logic [BEAT_W-1:0]    beat_q;
    logic [STALL_W-1:0]   stall_q;
    logic [LINE_W-1:0]    resp_rdata_q;
    logic                 resp_err_q;
    logic                 cmd_oe_q, cmd_oe_d;
    logic                 data_oe_q, data_oe_d;
    logic                 resp_seen;
    logic                 beat_last;
    logic                 in_xfer;
    logic                 timeout_hit;
    logic [1:0]           cmd_drive;
    logic [BUS_SIZE-1:0]  data_drive;

    assign resp_seen   = (command == C2_RESPONSE);
    assign beat_last   = (beat_q == LAST_BEAT);
    assign in_xfer     = (state_q == WAIT) || (state_q == XFER);
    assign timeout_hit = in_xfer && !resp_seen && (stall_q == STALL_LAST);

    // Bus drivers come only from registered enables so reset releases them at once.
    assign cmd_drive  = write_q ? C2_WRITE : C2_READ;
    assign data_drive = wdata_q[beat_q*BUS_SIZE +: BUS_SIZE];
    assign command    = cmd_oe_q  ? cmd_drive  : 2'bz;
    assign data       = data_oe_q ? data_drive : {BUS_SIZE{1'bz}};

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == DONE);
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    assign address    = addr_q;

    // Next state, read-line assembly and next bus-drive enables.
    always_comb begin
        state_d = state_q;
        rbuf_d  = rbuf_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = CMD;
                end
            end
            CMD: begin
                state_d = WAIT;
            end
            WAIT, XFER: begin
                if (resp_seen) begin
                    if (!write_q) begin
                        rbuf_d[beat_q*BUS_SIZE +: BUS_SIZE] = data;
                    end
                    state_d = beat_last ? DONE : XFER;
                end else if (timeout_hit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        cmd_oe_d = (state_d == CMD);
        // The write flag is only captured on acceptance, so entering CMD looks at the request.
        if (state_d == CMD) begin
            data_oe_d = (state_q == IDLE) ? req_write : write_q;
        end else if ((state_d == WAIT) || (state_d == XFER)) begin
            data_oe_d = write_q;
        end else begin
            data_oe_d = 1'b0;
        end
    end

    // State register, request capture, beat/stall counters and response hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            write_q      <= 1'b0;
            wdata_q      <= '0;
            rbuf_q       <= '0;
            beat_q       <= '0;
            stall_q      <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            cmd_oe_q     <= 1'b0;
            data_oe_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rbuf_q    <= rbuf_d;
            cmd_oe_q  <= cmd_oe_d;
            data_oe_q <= data_oe_d;

            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_addr;
                        write_q <= req_write;
                        wdata_q <= req_wdata;
                        rbuf_q  <= '0;
                        beat_q  <= '0;
                        stall_q <= '0;
                    end
                end
                WAIT, XFER: begin
                    if (resp_seen) begin
                        stall_q <= '0;
                        // The last beat ends the transfer, so the index never wraps.
                        if (!beat_last) begin
                            beat_q <= beat_q + BEAT_W'(1);
                        end
                    end else begin
                        stall_q <= stall_q + STALL_W'(1);
                    end
                end
                DONE: begin
                    addr_q  <= '0;
                    beat_q  <= '0;
                    stall_q <= '0;
                end
                default: begin
                end
            endcase

            if (state_d == DONE) begin
                resp_err_q   <= timeout_hit;
                resp_rdata_q <= (timeout_hit || write_q) ? '0 : rbuf_d;
            end else begin
                resp_err_q   <= 1'b0;
            end
        end
    end

endmodule
